rv32i_load_store_unit: RTL and testbench
========================================

# rv32i_load_store_unit

Memory-stage load/store unit for the pipelined rv32i core. It sits between the execute-stage ALU result and the single-ported, word-wide data memory, and feeds load data to writeback. It handles byte, halfword and word accesses, using read-modify-write for sub-word stores, with sign or zero extension on loads. It drives `busy` so the hazard unit can stall upstream stages.

## Interface
- No parameters; XLEN fixed at 32.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  access request from execute/memory stage
- `req_ready`  out  1  request accepted on the cycle where `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
- `req_addr`  in  32  byte address (ALU result)
- `req_wr_data`  in  32  store data (rs2), right-aligned
- `rsp_valid`  out  1  one-cycle pulse; load data valid
- `rsp_rd_data`  out  32  extended load data
- `fault`  out  1  one-cycle pulse; request was misaligned or used an illegal funct3, and no memory access occurred
- `busy`  out  1  equals `~req_ready`; stall request to upstream stages
- `mem_addr`  out  32  word address, with bits [1:0] always 0
- `mem_wr_data`  out  32  memory write data
- `mem_wr_ena`  out  1  memory write strobe; the write commits at the clock edge
- `mem_rd_data`  in  32  synchronous read: data for `mem_addr` at cycle N is valid in cycle N+1

## Operation
- **Byte lanes are little-endian.** Lane k is bits [8k+7:8k] and is selected by `addr[1:0]`. Halfword lanes are selected by `addr[1]`.
- **Legality.** A halfword access requires `addr[0]==0`. A word access requires `addr[1:0]==0`. Load funct3 values 011, 110 and 111 are illegal. Store funct3 values other than 000, 001 and 010 are illegal.
- **FSM states:** IDLE, LOAD_WAIT, RMW_WRITE.
- **IDLE**
  - `req_ready`=1.
  - `mem_addr` = {`req_addr`[31:2], 2'b00}, driven combinationally.
  - On accept:
    - Illegal request: `fault`=1 next cycle, no write, stay in IDLE.
    - Load: latch funct3 and `addr[1:0]`, go to LOAD_WAIT.
    - SW: `mem_wr_ena`=1 and `mem_wr_data`=`req_wr_data` in the accept cycle, stay in IDLE.
    - SB/SH: the read is issued in the accept cycle. Latch word address, offset, size and data, then go to RMW_WRITE.
- **LOAD_WAIT**
  - `req_ready`=0.
  - Extract the lane from `mem_rd_data`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) it.
  - Register the result into `rsp_rd_data` and set `rsp_valid`=1 for the next cycle. Go to IDLE.
- **RMW_WRITE**
  - `req_ready`=0.
  - `mem_addr` = latched word address, `mem_wr_ena`=1.
  - `mem_wr_data` = `mem_rd_data` with the target lane(s) replaced by the low byte/halfword of the latched data. Go to IDLE.
- **Outside the cases above,** `mem_wr_ena`=0. `req_valid` while busy is ignored; the requester holds the request.
- **Stores** produce no `rsp_valid`.

## Timing
- **Reset values:** state IDLE, `rsp_valid`=0, `rsp_rd_data`=0, `fault`=0, latched registers 0, `req_ready`=1 in the cycle after reset.
- **`mem_wr_ena` is gated by `~rst`.** Reset in the RMW_WRITE cycle suppresses the write, and the block is in IDLE on the next cycle.
- **Load:** accepted at T, LOAD_WAIT at T+1, `rsp_valid` at T+2, next accept possible at T+2.
- **SW:** one cycle; back-to-back stores every cycle.
- **SB/SH:** read at T, write at T+1, next accept at T+2.
- **Fault:** pulse at T+1, and the block can accept again at T+1.

## Structure
- Add to the shared `rv32i_defines` package: a `mem_funct3_t` enum covering LB/LH/LW/LBU/LHU and SB/SH/SW.
- The FSM state enum is local to the module.
- One combinational sub-module, `rv32i_lsu_align`, contains:
  - load lane extraction and extension, from (word, offset, funct3) to data;
  - store lane merge, from (old word, new data, offset, funct3) to word.
- Pipeline registers use the existing `register` module.

## Test plan
- Memory[0x40] = 0x80F17F02:
  - LB 0x42 gives 0xFFFFFFF1; LBU 0x42 gives 0x000000F1.
  - LH 0x42 gives 0xFFFF80F1; LHU 0x40 gives 0x00007F02.
  - Each `rsp_valid` arrives exactly 2 cycles after accept.
- SW 0x44 with data 0xDEADBEEF, then SW 0x48 with data 0x1 on the next cycle:
  - both writes occur in their accept cycles;
  - `req_ready` stays 1 and `fault`=0.
- SB 0x43 with data 0x123456AA over 0x80F17F02:
  - read at T, `mem_wr_ena` at T+1 with 0xAAF17F02;
  - `busy`=1 only at T+1.
- SH 0x41 and LW 0x42 each produce a `fault` pulse at T+1, no `mem_wr_ena`, memory unchanged. Load funct3=011 also faults.
- `rst` asserted during the RMW_WRITE cycle of SB 0x40:
  - `mem_wr_ena`=0 and the memory word is unchanged;
  - next cycle `req_ready`=1, `rsp_valid`=0.
- Load accepted at T with `req_valid` held through T+1 carrying an SW:
  - the SW is not accepted at T+1;
  - the SW is accepted and written at T+2, coincident with the load's `rsp_valid`.

Source files
------------

// File: rtl/rv32i_defines.sv
// Shared rv32i definitions: data-memory access encodings and the legality
// rule used by the load/store unit.
package rv32i_defines;

  // funct3 encodings for data-memory accesses. Stores reuse the size
  // encodings of the signed loads: SB = LB, SH = LH, SW = LW.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,  // LB / SB
    MEM_H  = 3'b001,  // LH / SH
    MEM_W  = 3'b010,  // LW / SW
    MEM_BU = 3'b100,  // LBU
    MEM_HU = 3'b101   // LHU
  } mem_funct3_t;

  // True when funct3 names a real access of this direction and the byte
  // offset is naturally aligned for the access size.
  function automatic logic mem_req_legal(input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic legal;
    case (funct3)
      MEM_B:   legal = 1'b1;
      MEM_H:   legal = ~offset[0];
      MEM_W:   legal = (offset == 2'b00);
      MEM_BU:  legal = ~store;
      MEM_HU:  legal = ~store & ~offset[0];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv32i_load_store_unit_if.sv
// Bundle between the memory stage, the load/store unit and the data memory.
interface rv32i_load_store_unit_if;

  // request from the memory stage
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;

  // response / status back to the pipeline
  logic        rsp_valid;
  logic [31:0] rsp_rd_data;
  logic        fault;
  logic        busy;

  // single-ported, word-wide data memory
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  // pipeline side: issues requests, receives load data and status
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wr_data,
    input  req_ready, rsp_valid, rsp_rd_data, fault, busy
  );

  // load/store unit side
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wr_data,
    output req_ready, rsp_valid, rsp_rd_data, fault, busy,
    output mem_addr, mem_wr_data, mem_wr_ena,
    input  mem_rd_data
  );

  // data memory side
  modport mem (
    input  mem_addr, mem_wr_data, mem_wr_ena,
    output mem_rd_data
  );

endinterface

// File: rtl/register.sv
// Generic pipeline register with synchronous, active-high reset.
module register #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // capture d every cycle, forced to RESET_VALUE while rst is high
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register samples
    // its input from before the edge, independent of process order.
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end

endmodule

// File: rtl/rv32i_lsu_align.sv
// Byte-lane steering for the load/store unit: load extraction/extension and
// the sub-word merge used by read-modify-write stores. Purely combinational.
module rv32i_lsu_align
  import rv32i_defines::*;
(
  // load path
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_offset,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data,
  // store merge path
  input  logic [31:0] st_old_word,
  input  logic [15:0] st_new_data,
  input  logic [1:0]  st_offset,
  input  logic [2:0]  st_funct3,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // pick the addressed lane and sign- or zero-extend it
  always_comb begin
    // NOTE: combinational blocks use blocking assignment so later lines see
    // the values computed above them in the same evaluation.
    ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
    ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_data = {24'h0, ld_byte};
      MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_HU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // overwrite only the target lane(s) of the old word
  always_comb begin
    st_word = st_old_word;
    case (st_funct3)
      MEM_B: st_word[{st_offset, 3'b000} +: 8] = st_new_data[7:0];
      MEM_H: begin
        if (st_offset[1]) st_word[31:16] = st_new_data;
        else              st_word[15:0]  = st_new_data;
      end
      default: st_word = st_old_word;
    endcase
  end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// Memory-stage load/store unit: word stores in one cycle, loads in two,
// sub-word stores by read-modify-write, misaligned/illegal requests fault.
module rv32i_load_store_unit
  import rv32i_defines::*;
(
  input  logic                     clk,
  input  logic                     rst,
  rv32i_load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_RMW_WRITE
  } state_t;

  state_t      state_q, state_d;

  logic        rsp_valid_d, rsp_valid_q;
  logic [31:0] rsp_rd_data_d, rsp_rd_data_q;
  logic        fault_d, fault_q;
  logic [2:0]  funct3_d, funct3_q;
  logic [1:0]  offset_d, offset_q;
  logic [29:0] word_addr_d, word_addr_q;
  logic [15:0] st_data_d, st_data_q;

  logic        req_ready;
  logic        accept;
  logic        req_legal;
  logic        wr_ena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept    = bus.req_valid & req_ready;
  assign req_legal = mem_req_legal(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

  rv32i_lsu_align u_align (
    .ld_word     (bus.mem_rd_data),
    .ld_offset   (offset_q),
    .ld_funct3   (funct3_q),
    .ld_data     (ld_data),
    .st_old_word (bus.mem_rd_data),
    .st_new_data (st_data_q),
    .st_offset   (offset_q),
    .st_funct3   (funct3_q),
    .st_word     (st_word)
  );

  // next-state, latch enables and memory-port drive
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_addr      = {bus.req_addr[31:2], 2'b00};
    mem_wr_data   = '0;
    wr_ena        = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rd_data_d = rsp_rd_data_q;
    fault_d       = 1'b0;
    funct3_d      = funct3_q;
    offset_d      = offset_q;
    word_addr_d   = word_addr_q;
    st_data_d     = st_data_q;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (!req_legal) begin
            fault_d = 1'b1;
          end else if (!bus.req_store) begin
            funct3_d = bus.req_funct3;
            offset_d = bus.req_addr[1:0];
            state_d  = ST_LOAD_WAIT;
          end else if (bus.req_funct3 == MEM_W) begin
            wr_ena      = 1'b1;
            mem_wr_data = bus.req_wr_data;
          end else begin
            // sub-word store: this cycle's address issues the read
            funct3_d    = bus.req_funct3;
            offset_d    = bus.req_addr[1:0];
            word_addr_d = bus.req_addr[31:2];
            st_data_d   = bus.req_wr_data[15:0];
            state_d     = ST_RMW_WRITE;
          end
        end
      end
      ST_LOAD_WAIT: begin
        rsp_rd_data_d = ld_data;
        rsp_valid_d   = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_RMW_WRITE: begin
        mem_addr    = {word_addr_q, 2'b00};
        wr_ena      = 1'b1;
        mem_wr_data = st_word;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  register #(.WIDTH(1))  u_rsp_valid   (.clk(clk), .rst(rst), .d(rsp_valid_d),   .q(rsp_valid_q));
  register #(.WIDTH(32)) u_rsp_rd_data (.clk(clk), .rst(rst), .d(rsp_rd_data_d), .q(rsp_rd_data_q));
  register #(.WIDTH(1))  u_fault       (.clk(clk), .rst(rst), .d(fault_d),       .q(fault_q));
  register #(.WIDTH(3))  u_funct3      (.clk(clk), .rst(rst), .d(funct3_d),      .q(funct3_q));
  register #(.WIDTH(2))  u_offset      (.clk(clk), .rst(rst), .d(offset_d),      .q(offset_q));
  register #(.WIDTH(30)) u_word_addr   (.clk(clk), .rst(rst), .d(word_addr_d),   .q(word_addr_q));
  register #(.WIDTH(16)) u_st_data     (.clk(clk), .rst(rst), .d(st_data_d),     .q(st_data_q));

  // a reset landing on a write cycle must not corrupt memory
  assign bus.mem_wr_ena  = wr_ena & ~rst;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.req_ready   = req_ready;
  assign bus.busy        = ~req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd_data = rsp_rd_data_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed self-checking bench for rv32i_load_store_unit with a small
// synchronous-read data memory model.
module tb_rv32i_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [0:63];

  rv32i_load_store_unit_if lsu_if ();

  rv32i_load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (lsu_if)
  );

  always #5 clk = ~clk;

  // word memory, write-first-cycle commit, read data one cycle later
  always @(posedge clk) begin
    if (lsu_if.mem_wr_ena) mem[lsu_if.mem_addr[7:2]] <= lsu_if.mem_wr_data;
    lsu_if.mem_rd_data <= mem[lsu_if.mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    lsu_if.req_valid   = v;
    lsu_if.req_store   = st;
    lsu_if.req_funct3  = f3;
    lsu_if.req_addr    = a;
    lsu_if.req_wr_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // load accepted at T, response checked exactly at T+2
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    #1;
    check({tag, "_ready_T"}, {31'h0, lsu_if.req_ready}, 32'h1);
    check({tag, "_addr_T"}, lsu_if.mem_addr, {a[31:2], 2'b00});
    tick();
    idle();
    #1;
    check({tag, "_busy_T1"}, {31'h0, lsu_if.busy}, 32'h1);
    check({tag, "_rsp_T1"}, {31'h0, lsu_if.rsp_valid}, 32'h0);
    tick();
    check({tag, "_rsp_T2"}, {31'h0, lsu_if.rsp_valid}, 32'h1);
    check({tag, "_data"}, lsu_if.rsp_rd_data, exp);
    check({tag, "_ready_T2"}, {31'h0, lsu_if.req_ready}, 32'h1);
  endtask

  // illegal request: fault at T+1 only, no write
  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    drive(1'b1, st, f3, a, 32'h5A5A5A5A);
    #1;
    check({tag, "_wr_T"}, {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    tick();
    idle();
    #1;
    check({tag, "_fault_T1"}, {31'h0, lsu_if.fault}, 32'h1);
    check({tag, "_ready_T1"}, {31'h0, lsu_if.req_ready}, 32'h1);
    check({tag, "_wr_T1"}, {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    tick();
    check({tag, "_fault_T2"}, {31'h0, lsu_if.fault}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h80F17F02;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_ready", {31'h0, lsu_if.req_ready}, 32'h1);
    check("rst_busy", {31'h0, lsu_if.busy}, 32'h0);
    check("rst_rsp_valid", {31'h0, lsu_if.rsp_valid}, 32'h0);
    check("rst_rsp_data", lsu_if.rsp_rd_data, 32'h0);
    check("rst_fault", {31'h0, lsu_if.fault}, 32'h0);
    check("rst_wr", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    tick();

    // loads from 0x80F17F02
    do_load("lb42",  3'b000, 32'h42, 32'hFFFFFFF1);
    do_load("lbu42", 3'b100, 32'h42, 32'h000000F1);
    do_load("lh42",  3'b001, 32'h42, 32'hFFFF80F1);
    do_load("lhu40", 3'b101, 32'h40, 32'h00007F02);
    do_load("lbu43", 3'b100, 32'h43, 32'h00000080);
    do_load("lb41",  3'b000, 32'h41, 32'h0000007F);
    do_load("lw40",  3'b010, 32'h40, 32'h80F17F02);
    tick();
    check("rsp_pulse_end", {31'h0, lsu_if.rsp_valid}, 32'h0);

    // back-to-back word stores
    drive(1'b1, 1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
    #1;
    check("sw1_wr", {31'h0, lsu_if.mem_wr_ena}, 32'h1);
    check("sw1_data", lsu_if.mem_wr_data, 32'hDEADBEEF);
    check("sw1_addr", lsu_if.mem_addr, 32'h44);
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h48, 32'h00000001);
    #1;
    check("sw2_ready", {31'h0, lsu_if.req_ready}, 32'h1);
    check("sw2_wr", {31'h0, lsu_if.mem_wr_ena}, 32'h1);
    check("sw2_data", lsu_if.mem_wr_data, 32'h00000001);
    check("sw2_addr", lsu_if.mem_addr, 32'h48);
    check("sw2_fault", {31'h0, lsu_if.fault}, 32'h0);
    tick();
    idle();
    #1;
    check("sw_after_fault", {31'h0, lsu_if.fault}, 32'h0);
    check("sw_after_rsp", {31'h0, lsu_if.rsp_valid}, 32'h0);
    check("sw_mem44", mem[17], 32'hDEADBEEF);
    check("sw_mem48", mem[18], 32'h00000001);
    tick();
    do_load("lw44", 3'b010, 32'h44, 32'hDEADBEEF);

    // SB 0x43 read-modify-write
    drive(1'b1, 1'b1, 3'b000, 32'h43, 32'h123456AA);
    #1;
    check("sb_busy_T", {31'h0, lsu_if.busy}, 32'h0);
    check("sb_wr_T", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    check("sb_addr_T", lsu_if.mem_addr, 32'h40);
    tick();
    idle();
    #1;
    check("sb_busy_T1", {31'h0, lsu_if.busy}, 32'h1);
    check("sb_wr_T1", {31'h0, lsu_if.mem_wr_ena}, 32'h1);
    check("sb_data_T1", lsu_if.mem_wr_data, 32'hAAF17F02);
    check("sb_addr_T1", lsu_if.mem_addr, 32'h40);
    tick();
    check("sb_busy_T2", {31'h0, lsu_if.busy}, 32'h0);
    check("sb_wr_T2", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    check("sb_rsp_T2", {31'h0, lsu_if.rsp_valid}, 32'h0);
    check("sb_mem", mem[16], 32'hAAF17F02);

    // SH 0x42 over 0xAAF17F02 replaces the upper halfword
    drive(1'b1, 1'b1, 3'b001, 32'h42, 32'h9999BEEF);
    tick();
    idle();
    #1;
    check("sh_data_T1", lsu_if.mem_wr_data, 32'hBEEF7F02);
    tick();
    check("sh_mem", mem[16], 32'hBEEF7F02);
    do_load("lh_after_sh", 3'b001, 32'h42, 32'hFFFFBEEF);

    // illegal requests
    do_fault("sh41",   1'b1, 3'b001, 32'h41);
    do_fault("lw42",   1'b0, 3'b010, 32'h42);
    do_fault("ld011",  1'b0, 3'b011, 32'h40);
    do_fault("st100",  1'b1, 3'b100, 32'h40);
    check("fault_mem", mem[16], 32'hBEEF7F02);

    // fault, then a new request accepted in the fault-pulse cycle
    drive(1'b1, 1'b0, 3'b001, 32'h43, 32'h0);
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    #1;
    check("refire_fault", {31'h0, lsu_if.fault}, 32'h1);
    check("refire_ready", {31'h0, lsu_if.req_ready}, 32'h1);
    tick();
    idle();
    tick();
    check("refire_rsp", {31'h0, lsu_if.rsp_valid}, 32'h1);
    check("refire_data", lsu_if.rsp_rd_data, 32'hBEEF7F02);
    tick();

    // reset during the RMW write cycle of SB 0x40
    drive(1'b1, 1'b1, 3'b000, 32'h40, 32'h00000055);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("rmw_rst_wr", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rmw_rst_ready", {31'h0, lsu_if.req_ready}, 32'h1);
    check("rmw_rst_rsp", {31'h0, lsu_if.rsp_valid}, 32'h0);
    check("rmw_rst_data", lsu_if.rsp_rd_data, 32'h0);
    check("rmw_rst_wr2", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    check("rmw_rst_mem", mem[16], 32'hBEEF7F02);
    tick();

    // load with a store held behind it while busy
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h48, 32'hCAFEF00D);
    #1;
    check("hold_ready_T1", {31'h0, lsu_if.req_ready}, 32'h0);
    check("hold_wr_T1", {31'h0, lsu_if.mem_wr_ena}, 32'h0);
    tick();
    check("hold_ready_T2", {31'h0, lsu_if.req_ready}, 32'h1);
    check("hold_wr_T2", {31'h0, lsu_if.mem_wr_ena}, 32'h1);
    check("hold_wdata_T2", lsu_if.mem_wr_data, 32'hCAFEF00D);
    check("hold_addr_T2", lsu_if.mem_addr, 32'h48);
    check("hold_rsp_T2", {31'h0, lsu_if.rsp_valid}, 32'h1);
    check("hold_rdata_T2", lsu_if.rsp_rd_data, 32'hBEEF7F02);
    tick();
    idle();
    #1;
    check("hold_mem48", mem[18], 32'hCAFEF00D);
    check("hold_rsp_T3", {31'h0, lsu_if.rsp_valid}, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
